paddle_ctrl: RTL and testbench
==============================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter X_INIT, 412, paddle x_pos after reset.
REQ-002 Parameter X_MAX, 823, largest legal x_pos (1023 minus paddle width 200).
REQ-003 Parameter Y_FIXED, 700, constant y_pos of the paddle.
REQ-004 Parameter SPEED_MIN, 2, pixels per frame at movement start.
REQ-005 Parameter SPEED_MAX, 12, speed ceiling (acceleration build only).
REQ-006 pclk  input  1  pixel clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 vsync_in  input  1  vertical sync from the timing chain; its rising edge defines the frame tick.
REQ-009 btn_left  input  1  asynchronous button, move left while high.
REQ-010 btn_right  input  1  asynchronous button, move right while high.
REQ-011 x_pos  output  12  registered paddle left edge, drives the paddle drawing stage.
REQ-012 y_pos  output  12  registered; always Y_FIXED.
REQ-013 moving  output  1  registered; high while state is LEFT or RIGHT.

Function
REQ-014 Buttons SHALL pass through a 2-flop synchronizer before use; vsync_in SHALL be registered once for edge detection.
REQ-015 Frame tick SHALL be a one-pclk pulse when registered vsync goes 0->1; x_pos, speed and state change only on tick.
REQ-016 State machine SHALL have states IDLE, LEFT, RIGHT, evaluated on tick from synchronized buttons.
REQ-017 Left only -> LEFT; right only -> RIGHT; none or both -> IDLE.
REQ-018 Entry into LEFT or RIGHT from any other state SHALL load speed = SPEED_MIN, and that tick moves by SPEED_MIN.
REQ-019 In LEFT, x_pos SHALL become max(0, x_pos - speed), computed at 13-bit signed width so no underflow occurs.
REQ-020 In RIGHT, x_pos SHALL become min(X_MAX, x_pos + speed), computed at 13 bits so no overflow occurs.
REQ-021 In IDLE, x_pos SHALL hold and speed SHALL reset to SPEED_MIN.
REQ-022 Updated x_pos SHALL appear on the output one pclk after the tick pulse.
REQ-023 A button press SHALL reach the state machine no more than 3 pclk after its edge; a press shorter than one frame may be missed.
REQ-024 At a wall, state SHALL stay LEFT/RIGHT (moving = 1) while x_pos stays clamped.

Reset
REQ-025 On reset, x_pos = X_INIT, y_pos = Y_FIXED, moving = 0, state = IDLE, speed = SPEED_MIN, synchronizers and the edge register = 0, accel counter = 0.
REQ-026 A reset asserted mid-move SHALL take effect on the next pclk edge regardless of tick; the first tick after release evaluates from IDLE.

Configuration
REQ-027 Macro PADDLE_ACCEL_EN: when defined, a 2-bit frame counter SHALL increment speed by 1 every 4th consecutive tick in the same direction, saturating at SPEED_MAX; the counter clears on a direction change or IDLE.
REQ-028 Without PADDLE_ACCEL_EN, speed SHALL remain SPEED_MIN permanently, the counter logic SHALL be absent, and SPEED_MAX is unused.

Structure
REQ-029 Package arkanoid_pkg SHALL hold the screen constants (H_ACTIVE = 1024, V_ACTIVE = 768, PADDLE_W = 200, PADDLE_H = 20) and the paddle state enumeration; the X_MAX default SHALL derive from H_ACTIVE - 1 - PADDLE_W.
REQ-030 One sub-module, frame_tick (vsync register plus rising-edge pulse), SHALL be instantiated; the synchronizer stays inline.

Verification
REQ-031 Reset, then 3 ticks with no buttons -> x_pos = 412, y_pos = 700, moving = 0.
REQ-032 btn_right held for 5 ticks, no accel build -> x_pos = 422, moving = 1 from the first tick.
REQ-033 Start at 3, btn_left held for 2 ticks -> x_pos = 1 then 0, no wrap to 4095, moving remains 1.
REQ-034 Start at 820, btn_right held -> x_pos = 822, 823, 823.
REQ-035 Both buttons high -> IDLE, x_pos frozen; then swap from left to right mid-move -> first right step is SPEED_MIN.
REQ-036 PADDLE_ACCEL_EN, btn_right held for 12 ticks from 0 -> steps 2,2,2,2,3,3,3,3,4,4,4,4, so x_pos = 36; assert reset during tick 6 -> x_pos = 412 on the next pclk.

Source files
------------

// File: rtl/arkanoid_pkg.sv
// Screen geometry and paddle state shared by the arkanoid video blocks.
// Contents: screen/paddle constants, paddle FSM states, small const helper.
package arkanoid_pkg;

  localparam int H_ACTIVE   = 1024;
  localparam int V_ACTIVE   = 768;
  localparam int PADDLE_W   = 200;
  localparam int PADDLE_H   = 20;
  localparam int PADDLE_GAP = 48;

  // Rightmost left-edge that keeps the paddle fully on screen.
  localparam int X_MAX_DEF   = H_ACTIVE - 1 - PADDLE_W;
  localparam int Y_FIXED_DEF = V_ACTIVE - PADDLE_GAP - PADDLE_H;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } paddle_st_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Frame tick: registers vsync and emits a one-pclk pulse on its rising edge.
// Ports: pclk, reset (sync, active-high), i_vsync in; o_tick pulse out.
module frame_tick (
  input  logic pclk,
  input  logic reset,
  input  logic i_vsync,
  output logic o_tick
);

  logic r_vs;
  logic r_vs_d;

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_vs   <= 1'b0;
      r_vs_d <= 1'b0;
    end else begin
      r_vs   <= i_vsync;
      r_vs_d <= r_vs;
    end
  end

  assign o_tick = r_vs & ~r_vs_d;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle controller: moves the paddle once per frame from the two buttons.
// Ports: pclk, reset, vsync_in, btn_left, btn_right in; x_pos, y_pos, moving out.
// Build option PADDLE_ACCEL_EN adds per-frame speed ramp up to SPEED_MAX.
module paddle_ctrl
  import arkanoid_pkg::*;
#(
  parameter int X_INIT    = 412,
  parameter int X_MAX     = X_MAX_DEF,
  parameter int Y_FIXED   = Y_FIXED_DEF,
  parameter int SPEED_MIN = 2,
  parameter int SPEED_MAX = 12
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        vsync_in,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        moving
);

  // Wide enough for either speed bound.
  localparam int SPD_W =
    $clog2(imax(SPEED_MIN, SPEED_MAX) + 1);

  logic [1:0]       r_bl;
  logic [1:0]       r_br;
  logic             w_l;
  logic             w_r;
  logic             w_tick;
  paddle_st_e       r_st;
  paddle_st_e       w_st_nxt;
  logic             w_entry;
  logic [SPD_W-1:0] w_step;
  logic [11:0]      r_x;
  logic [11:0]      r_y;
  logic             r_mov;
  logic [12:0]      w_sum;
  logic signed [12:0] w_dif;
  logic [11:0]      w_x_nxt;

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_bl <= 2'b00;
      r_br <= 2'b00;
    end else begin
      r_bl <= {r_bl[0], btn_left};
      r_br <= {r_br[0], btn_right};
    end
  end

  assign w_l = r_bl[1];
  assign w_r = r_br[1];

  frame_tick u_tick (
    .pclk    (pclk),
    .reset   (reset),
    .i_vsync (vsync_in),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_st_nxt = r_st;
    if (w_tick) begin
      unique case (1'b1)
        (w_l && !w_r): w_st_nxt = ST_LEFT;
        (w_r && !w_l): w_st_nxt = ST_RIGHT;
        default:       w_st_nxt = ST_IDLE;
      endcase
    end
  end

  // Any change into a moving state restarts at minimum speed.
  assign w_entry = (w_st_nxt != r_st) &&
                   (w_st_nxt != ST_IDLE);

`ifdef PADDLE_ACCEL_EN
  logic [SPD_W-1:0] r_speed;
  logic [SPD_W-1:0] w_inc;
  logic [1:0]       r_cnt;

  assign w_inc = (r_speed >= SPD_W'(SPEED_MAX)) ?
                 SPD_W'(SPEED_MAX) : r_speed + 1'b1;

  // r_cnt is the run length mod 4; wrapping to 0 bumps speed.
  always_comb begin
    w_step = r_speed;
    if (w_entry) begin
      w_step = SPD_W'(SPEED_MIN);
    end else if (r_cnt == 2'd0) begin
      w_step = w_inc;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_speed <= SPD_W'(SPEED_MIN);
      r_cnt   <= 2'd0;
    end else if (w_tick) begin
      if (w_st_nxt == ST_IDLE) begin
        r_speed <= SPD_W'(SPEED_MIN);
        r_cnt   <= 2'd0;
      end else if (w_entry) begin
        r_speed <= SPD_W'(SPEED_MIN);
        r_cnt   <= 2'd1;
      end else begin
        r_speed <= w_step;
        r_cnt   <= r_cnt + 2'd1;
      end
    end
  end
`else
  assign w_step = SPD_W'(SPEED_MIN);
`endif

  // One extra bit keeps both the wall clamps exact.
  assign w_sum = {1'b0, r_x} + 13'(w_step);
  assign w_dif = {1'b0, r_x} - 13'(w_step);

  always_comb begin
    w_x_nxt = r_x;
    unique case (w_st_nxt)
      ST_LEFT:
        w_x_nxt = (w_dif < 0) ? 12'd0 : w_dif[11:0];
      ST_RIGHT:
        w_x_nxt = (w_sum > 13'(X_MAX)) ?
                  12'(X_MAX) : w_sum[11:0];
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_st  <= ST_IDLE;
      r_x   <= 12'(X_INIT);
      r_y   <= 12'(Y_FIXED);
      r_mov <= 1'b0;
    end else begin
      r_y <= 12'(Y_FIXED);
      if (w_tick) begin
        r_st  <= w_st_nxt;
        r_x   <= w_x_nxt;
        r_mov <= (w_st_nxt != ST_IDLE);
      end
    end
  end

  assign x_pos  = r_x;
  assign y_pos  = r_y;
  assign moving = r_mov;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: frame-level model plus hand-computed checkpoints.
// Ports driven: pclk, reset, vsync_in, btn_left, btn_right.
module tb_paddle_ctrl;

  localparam int X_INIT    = 412;
  localparam int X_MAX     = 823;
  localparam int Y_FIXED   = 700;
  localparam int SPEED_MIN = 2;
  localparam int SPEED_MAX = 12;

  logic        pclk      = 1'b0;
  logic        reset     = 1'b1;
  logic        vsync_in  = 1'b0;
  logic        btn_left  = 1'b0;
  logic        btn_right = 1'b0;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        moving;

  int errs  = 0;
  int total = 0;
  bit chk_en = 1'b0;

  int m_x;
  int m_dir;
  int m_run;
  bit m_mov;

  paddle_ctrl dut (
    .pclk      (pclk),
    .reset     (reset),
    .vsync_in  (vsync_in),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .moving    (moving)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input int got,
                     input int exp);
    total++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d",
               nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x   = X_INIT;
    m_dir = 0;
    m_run = 0;
    m_mov = 1'b0;
  endtask

  // Frame-level rule: direction from buttons, step from run length.
  task automatic model_tick(input bit l, input bit r);
    int nd;
    int stp;
`ifdef PADDLE_ACCEL_EN
    int ext;
`endif
    nd = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
    if (nd == 0) m_run = 0;
    else if (nd != m_dir) m_run = 1;
    else m_run++;
    m_dir = nd;
    m_mov = (nd != 0);
    stp = SPEED_MIN;
`ifdef PADDLE_ACCEL_EN
    if (nd != 0) begin
      ext = (m_run - 1) / 4;
      stp = (SPEED_MIN + ext > SPEED_MAX) ?
            SPEED_MAX : SPEED_MIN + ext;
    end
`endif
    if (nd == 1)
      m_x = (m_x - stp < 0) ? 0 : m_x - stp;
    else if (nd == 2)
      m_x = (m_x + stp > X_MAX) ? X_MAX : m_x + stp;
  endtask

  always @(posedge pclk) begin
    #2;
    if (chk_en) begin
      chk("x_pos", int'(x_pos), m_x);
      chk("y_pos", int'(y_pos), Y_FIXED);
      chk("moving", int'(moving), int'(m_mov));
    end
  end

  // Buttons settle well past the synchronizer before vsync rises.
  task automatic frame(input bit l, input bit r);
    @(negedge pclk);
    btn_left  = l;
    btn_right = r;
    repeat (3) @(negedge pclk);
    vsync_in = 1'b1;
    @(posedge pclk);
    @(posedge pclk);
    #1 model_tick(l, r);
    @(negedge pclk);
    vsync_in = 1'b0;
    repeat (2) @(negedge pclk);
  endtask

  // Reset lands on the same edge the tick would update x_pos.
  task automatic tick_reset(input bit l, input bit r);
    @(negedge pclk);
    btn_left  = l;
    btn_right = r;
    repeat (3) @(negedge pclk);
    vsync_in = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    reset = 1'b1;
    @(posedge pclk);
    #1 model_reset();
    @(negedge pclk);
    chk("rst_mid_x", int'(x_pos), 412);
    chk("rst_mid_mov", int'(moving), 0);
    reset    = 1'b0;
    vsync_in = 1'b0;
    repeat (2) @(negedge pclk);
  endtask

  initial begin
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    reset = 1'b0;
    model_reset();
    chk("rst_x", int'(x_pos), 412);
    chk("rst_y", int'(y_pos), 700);
    chk("rst_mov", int'(moving), 0);
    chk_en = 1'b1;

    repeat (3) frame(1'b0, 1'b0);
    chk("idle_x", int'(x_pos), 412);
    chk("idle_mov", int'(moving), 0);

`ifndef PADDLE_ACCEL_EN
    frame(1'b0, 1'b1);
    chk("right_first_mov", int'(moving), 1);
    repeat (4) frame(1'b0, 1'b1);
    chk("right5_x", int'(x_pos), 422);

    frame(1'b1, 1'b1);
    chk("both_x", int'(x_pos), 422);
    chk("both_mov", int'(moving), 0);

    repeat (199) frame(1'b0, 1'b1);
    chk("right_820", int'(x_pos), 820);
    frame(1'b0, 1'b1);
    chk("right_822", int'(x_pos), 822);
    frame(1'b0, 1'b1);
    chk("right_823a", int'(x_pos), 823);
    frame(1'b0, 1'b1);
    chk("right_823b", int'(x_pos), 823);
    chk("wall_r_mov", int'(moving), 1);

    repeat (410) frame(1'b1, 1'b0);
    chk("left_3", int'(x_pos), 3);
    frame(1'b1, 1'b0);
    chk("left_1", int'(x_pos), 1);
    frame(1'b1, 1'b0);
    chk("left_0", int'(x_pos), 0);
    frame(1'b1, 1'b0);
    chk("left_0_hold", int'(x_pos), 0);
    chk("wall_l_mov", int'(moving), 1);

    repeat (3) frame(1'b0, 1'b1);
    chk("r3_x", int'(x_pos), 6);
    frame(1'b1, 1'b0);
    chk("l1_x", int'(x_pos), 4);
    frame(1'b0, 1'b1);
    chk("swap_step", int'(x_pos), 6);

    frame(1'b0, 1'b1);
    tick_reset(1'b0, 1'b1);
    frame(1'b0, 1'b1);
    chk("post_rst_x", int'(x_pos), 414);
    chk("post_rst_mov", int'(moving), 1);
`else
    repeat (60) frame(1'b1, 1'b0);
    chk("acc_left_wall", int'(x_pos), 0);
    frame(1'b0, 1'b0);
    repeat (12) frame(1'b0, 1'b1);
    chk("acc_right12", int'(x_pos), 36);
    chk("acc_mov", int'(moving), 1);

    frame(1'b1, 1'b0);
    frame(1'b0, 1'b1);
    chk("acc_swap_step", int'(x_pos), 36);

    frame(1'b0, 1'b0);
    repeat (5) frame(1'b0, 1'b1);
    chk("acc_run5_x", int'(x_pos), 47);
    tick_reset(1'b0, 1'b1);
    frame(1'b0, 1'b1);
    chk("acc_post_rst", int'(x_pos), 414);
`endif

    chk_en = 1'b0;
    repeat (3) @(negedge pclk);
    $display("Result: errors=%0d of %0d checks",
             errs, total);
    $finish;
  end

endmodule
